// File: rtl/hba_pkg.sv
// HBA bus arbiter shared definitions: arbiter state encoding and
// default bus widths.
package hba_pkg;

   localparam int HBA_NUM_MASTERS    = 2;
   localparam int HBA_DBUS_WIDTH     = 8;
   localparam int HBA_ADDR_WIDTH     = 12;
   localparam int HBA_TIMEOUT_CYCLES = 255;
   localparam int HBA_WDOG_WIDTH     = 16;

   localparam logic [1:0] HBA_ST_IDLE    = 2'd0;
   localparam logic [1:0] HBA_ST_GRANT   = 2'd1;
   localparam logic [1:0] HBA_ST_RELEASE = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = HBA_ST_IDLE,
      GRANT   = HBA_ST_GRANT,
      RELEASE = HBA_ST_RELEASE
   } hba_state_t;

endpackage

// File: rtl/hba_rr_pick.sv
// Combinational round-robin picker: search starts one past the previous
// winner and wraps, yielding a one-hot winner and its index.
module hba_rr_pick #(
   parameter  int NUM_MASTERS = 2,
   localparam int IW          = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] request,
   input  logic [IW-1:0]          last,
   output logic [NUM_MASTERS-1:0] pick_onehot,
   output logic [IW-1:0]          pick_idx,
   output logic                   pick_valid
);

   always_comb begin : search
      int   cand;
      logic found;
      pick_onehot = '0;
      pick_idx    = last;
      found       = 1'b0;
      cand        = 0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand = (int'(last) + k) % NUM_MASTERS;
         if (!found && request[cand]) begin
            found             = 1'b1;
            pick_idx          = IW'(cand);
            pick_onehot[cand] = 1'b1;
         end
      end
   end

   assign pick_valid = |request;

endmodule

// File: rtl/hba_arbiter.sv
// HBA round-robin bus arbiter: grants one master at a time, merges its
// address/control/data onto the slave bus, and reclaims a stuck bus.
module hba_arbiter
   import hba_pkg::*;
#(
   parameter int NUM_MASTERS    = HBA_NUM_MASTERS,
   parameter int DBUS_WIDTH     = HBA_DBUS_WIDTH,
   parameter int ADDR_WIDTH     = HBA_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = HBA_TIMEOUT_CYCLES
) (
   input  logic                             hba_clk,
   input  logic                             hba_reset_n,
   input  logic [NUM_MASTERS-1:0]           hba_mrequest,
   output logic [NUM_MASTERS-1:0]           hba_mgrant,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] hba_abus_master,
   input  logic [NUM_MASTERS-1:0]           hba_rnw_master,
   input  logic [NUM_MASTERS-1:0]           hba_select_master,
   input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] hba_dbus_master,
   input  logic                             hba_xferack,
   output logic [ADDR_WIDTH-1:0]            hba_abus,
   output logic                             hba_rnw,
   output logic                             hba_select,
   output logic [DBUS_WIDTH-1:0]            hba_dbus_wr,
   output logic                             hba_timeout
);

   localparam int IW = $clog2(NUM_MASTERS);
   localparam logic [HBA_WDOG_WIDTH-1:0] WDOG_LAST =
      HBA_WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

   hba_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IW-1:0]          last_q, last_d;
   logic                   timeout_q, timeout_d;
   logic [HBA_WDOG_WIDTH-1:0] wdog_q;

   logic [NUM_MASTERS-1:0] pick_onehot;
   logic [IW-1:0]          pick_idx;
   logic                   pick_valid;
   logic                   wdog_run;
   logic                   wdog_expire;
   logic                   winner_req;

   hba_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_pick (
      .request     (hba_mrequest),
      .last        (last_q),
      .pick_onehot (pick_onehot),
      .pick_idx    (pick_idx),
      .pick_valid  (pick_valid)
   );

   assign wdog_run    = hba_select & ~hba_xferack;
   assign wdog_expire = (state_q == GRANT) & wdog_run &
                        (wdog_q == WDOG_LAST);
   assign winner_req  = |(hba_mrequest & grant_q);

   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= IW'(NUM_MASTERS - 1);
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         timeout_q <= timeout_d;
      end
   end

   // Expiry takes priority over a same-cycle request drop.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_onehot;
               last_d  = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (wdog_expire) begin
               grant_d   = '0;
               timeout_d = 1'b1;
               state_d   = RELEASE;
            end else if (!winner_req) begin
               grant_d = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            grant_d = '0;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge hba_clk or negedge hba_reset_n) begin
      if (!hba_reset_n) begin
         wdog_q <= '0;
      end else if (state_q != GRANT || !wdog_run) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_q + 1'b1;
      end
   end

   // Masked OR merge, so idle masters need not drive zero.
   always_comb begin
      hba_abus    = '0;
      hba_dbus_wr = '0;
      hba_rnw     = 1'b0;
      hba_select  = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         hba_abus    = hba_abus |
            (hba_abus_master[i*ADDR_WIDTH +: ADDR_WIDTH] &
             {ADDR_WIDTH{grant_q[i]}});
         hba_dbus_wr = hba_dbus_wr |
            (hba_dbus_master[i*DBUS_WIDTH +: DBUS_WIDTH] &
             {DBUS_WIDTH{grant_q[i]}});
         hba_rnw     = hba_rnw | (hba_rnw_master[i] & grant_q[i]);
         hba_select  = hba_select | (hba_select_master[i] & grant_q[i]);
      end
   end

   assign hba_mgrant  = grant_q;
   assign hba_timeout = timeout_q;

endmodule

// File: tb/tb_hba_arbiter.sv
// Self-checking bench for hba_arbiter: scoreboard of expected bus
// observations, one task per scenario.
module tb_hba_arbiter;

   localparam int NM = 2;
   localparam int AW = 12;
   localparam int DW = 8;

   logic              hba_clk = 1'b0;
   logic              hba_reset_n;
   logic [NM-1:0]     hba_mrequest;
   logic [NM-1:0]     hba_mgrant;
   logic [NM*AW-1:0]  hba_abus_master;
   logic [NM-1:0]     hba_rnw_master;
   logic [NM-1:0]     hba_select_master;
   logic [NM*DW-1:0]  hba_dbus_master;
   logic              hba_xferack;
   logic [AW-1:0]     hba_abus;
   logic              hba_rnw;
   logic              hba_select;
   logic [DW-1:0]     hba_dbus_wr;
   logic              hba_timeout;

   always #5 hba_clk = ~hba_clk;

   hba_arbiter #(
      .NUM_MASTERS    (NM),
      .DBUS_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .hba_clk           (hba_clk),
      .hba_reset_n       (hba_reset_n),
      .hba_mrequest      (hba_mrequest),
      .hba_mgrant        (hba_mgrant),
      .hba_abus_master   (hba_abus_master),
      .hba_rnw_master    (hba_rnw_master),
      .hba_select_master (hba_select_master),
      .hba_dbus_master   (hba_dbus_master),
      .hba_xferack       (hba_xferack),
      .hba_abus          (hba_abus),
      .hba_rnw           (hba_rnw),
      .hba_select        (hba_select),
      .hba_dbus_wr       (hba_dbus_wr),
      .hba_timeout       (hba_timeout)
   );

   typedef struct packed {
      logic [NM-1:0] grant;
      logic [AW-1:0] abus;
      logic [DW-1:0] dbus;
      logic          rnw;
      logic          sel;
      logic          to;
   } obs_t;

   obs_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic obs_t mk(logic [NM-1:0] g, logic [AW-1:0] a,
                               logic [DW-1:0] d, logic r, logic s,
                               logic t);
      obs_t o;
      o.grant = g;
      o.abus  = a;
      o.dbus  = d;
      o.rnw   = r;
      o.sel   = s;
      o.to    = t;
      return o;
   endfunction

   function automatic obs_t sample();
      return mk(hba_mgrant, hba_abus, hba_dbus_wr, hba_rnw,
                hba_select, hba_timeout);
   endfunction

   task automatic cyc();
      @(posedge hba_clk);
      @(negedge hba_clk);
   endtask

   task automatic clear_masters();
      hba_mrequest      = '0;
      hba_abus_master   = '0;
      hba_rnw_master    = '0;
      hba_select_master = '0;
      hba_dbus_master   = '0;
      hba_xferack       = 1'b0;
   endtask

   task automatic test_reset();
      obs_t got, exp;
      clear_masters();
      hba_reset_n = 1'b0;
      #12;
      sb.push_back('0);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL reset got=%h exp=%h", got, exp);
      end
      @(negedge hba_clk);
      hba_reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb.push_back('0);
         cyc();
         got = sample();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_idle cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_rr_basic();
      logic [NM-1:0] req_t [6];
      logic [NM-1:0] gnt_t [6];
      obs_t got, exp;
      req_t = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
      gnt_t = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
      clear_masters();
      for (int i = 0; i < 6; i++) begin
         hba_mrequest = req_t[i];
         sb.push_back(mk(gnt_t[i], '0, '0, 1'b0, 1'b0, 1'b0));
         cyc();
         got = sample();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL rr_basic cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_merge();
      logic [NM-1:0] req_t [6];
      logic [NM-1:0] sel_t [6];
      logic          ack_t [6];
      obs_t          on, got, exp;
      req_t = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
      sel_t = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
      ack_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      on    = mk(2'b10, 12'h100, 8'h01, 1'b0, 1'b1, 1'b0);
      clear_masters();
      hba_abus_master = {12'h100, 12'hABC};
      hba_dbus_master = {8'h01, 8'hFF};
      hba_rnw_master  = 2'b01;
      for (int i = 0; i < 6; i++) begin
         hba_mrequest      = req_t[i];
         hba_select_master = sel_t[i];
         hba_xferack       = ack_t[i];
         sb.push_back(i < 4 ? on : obs_t'('0));
         cyc();
         got = sample();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL merge cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
      clear_masters();
   endtask

   task automatic test_back_to_back();
      logic [NM-1:0] w;
      obs_t          got, exp;
      clear_masters();
      for (int r = 0; r < 4; r++) begin
         w = (r % 2 == 0) ? 2'b01 : 2'b10;
         for (int c = 0; c < 6; c++) begin
            hba_mrequest = (c == 4) ? (2'b11 & ~w) : 2'b11;
            sb.push_back(mk(c < 4 ? w : 2'b00, '0, '0, 1'b0, 1'b0, 1'b0));
            cyc();
            got = sample();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL back_to_back r%0d c%0d got=%h exp=%h",
                        r, c, got, exp);
            end
         end
      end
      hba_mrequest = '0;
      sb.push_back('0);
      cyc();
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL back_to_back_end got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_timeout();
      obs_t a, b, t, got, exp;
      a = mk(2'b01, 12'h2A5, 8'h5A, 1'b1, 1'b1, 1'b0);
      b = mk(2'b10, 12'h0F0, 8'h33, 1'b0, 1'b0, 1'b0);
      t = mk(2'b00, '0, '0, 1'b0, 1'b0, 1'b1);
      clear_masters();
      hba_abus_master = {12'h0F0, 12'h2A5};
      hba_dbus_master = {8'h33, 8'h5A};
      hba_rnw_master  = 2'b01;
      for (int i = 0; i < 16; i++) begin
         hba_mrequest      = (i < 11) ? 2'b11 : (i < 14) ? 2'b01 : 2'b00;
         hba_select_master = (i < 14) ? 2'b01 : 2'b00;
         if (i < 8 || i == 13) sb.push_back(a);
         else if (i == 8)      sb.push_back(t);
         else if (i == 10)     sb.push_back(b);
         else                  sb.push_back('0);
         cyc();
         got = sample();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL timeout cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
      clear_masters();
   endtask

   task automatic test_async_reset();
      obs_t got, exp;
      clear_masters();
      hba_mrequest      = 2'b10;
      hba_select_master = 2'b10;
      hba_abus_master   = {12'h3C3, 12'h000};
      sb.push_back(mk(2'b10, 12'h3C3, 8'h00, 1'b0, 1'b1, 1'b0));
      cyc();
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL async_pre got=%h exp=%h", got, exp);
      end
      #2;
      hba_reset_n = 1'b0;
      #1;
      sb.push_back('0);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL async_rst got=%h exp=%h", got, exp);
      end
      clear_masters();
      hba_mrequest = 2'b11;
      @(posedge hba_clk);
      @(negedge hba_clk);
      hba_reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) hba_mrequest = 2'b00;
         sb.push_back(mk(i == 0 ? 2'b01 : 2'b00, '0, '0, 1'b0, 1'b0, 1'b0));
         cyc();
         got = sample();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL async_post cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_idle();
      obs_t got, exp;
      clear_masters();
      hba_abus_master   = '1;
      hba_dbus_master   = '1;
      hba_rnw_master    = '1;
      hba_select_master = '1;
      for (int i = 0; i < 100; i++) begin
         hba_xferack = 1'($urandom_range(1, 0));
         sb.push_back('0);
         cyc();
         got = sample();
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL idle cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
      clear_masters();
   endtask

   initial begin
      test_reset();
      test_rr_basic();
      test_merge();
      test_back_to_back();
      test_timeout();
      test_async_reset();
      test_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
